// File: rtl/gf_div.sv
// gf_div: sequential GF(2^8) divider, q = a * b^254 (= a / b for b != 0).
//
// The inverse b^254 is formed by square-and-multiply. b^254 is the product
// b^2 * b^4 * ... * b^128, so each of seven CALC cycles squares s and folds
// the new square into r. One MUL cycle then forms r * a. The result is held
// in DONE until the consumer accepts it.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   in_valid     operand pair a/b valid (accepted only in IDLE)
//   in_ready     block can accept an operand pair
//   a, b         dividend / divisor (field elements)
//   out_valid    q / div_by_zero valid
//   out_ready    consumer accepts the result
//   q            quotient a * b^-1
//   div_by_zero  the accepted b was zero (qualified by out_valid)
module gf_div #(
    parameter logic [7:0] POLY = 8'h1D
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] q,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Shift-and-add field multiply; a carry out of bit 7 is folded back in
    // with the low byte of the field polynomial.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) begin
                p = p ^ t;
            end else begin
                p = p;
            end
            if (t[7]) begin
                t = {t[6:0], 1'b0} ^ POLY;
            end else begin
                t = {t[6:0], 1'b0};
            end
        end
        return p;
    endfunction

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] s_q, s_d;
    logic [7:0] r_q, r_d;
    logic [7:0] a_reg_q, a_reg_d;
    logic       dz_q, dz_d;
    logic [7:0] quo_q, quo_d;
    logic       dbz_q, dbz_d;
    logic       out_valid_q, out_valid_d;
    logic       in_ready_q, in_ready_d;
    logic [7:0] s_sq;

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign q           = quo_q;
    assign div_by_zero = dbz_q;

    // Next-state and datapath for all registers; everything holds by default.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        s_d         = s_q;
        r_d         = r_q;
        a_reg_d     = a_reg_q;
        dz_d        = dz_q;
        quo_d       = quo_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        s_sq        = gf_mul(s_q, s_q);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_reg_d    = a;
                    s_d        = b;
                    r_d        = 8'h01;
                    cnt_d      = 3'd0;
                    dz_d       = (b == 8'h00);
                    in_ready_d = 1'b0;
                    state_d    = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                // r accumulates b^(2+4+...+2^k) after k steps.
                s_d   = s_sq;
                r_d   = gf_mul(r_q, s_sq);
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd6) begin
                    state_d = MUL;
                end else begin
                    state_d = CALC;
                end
            end
            MUL: begin
                quo_d       = gf_mul(r_q, a_reg_q);
                dbz_d       = dz_q;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State register with asynchronous reset to an idle, result-cleared block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            s_q         <= 8'h00;
            r_q         <= 8'h01;
            a_reg_q     <= 8'h00;
            dz_q        <= 1'b0;
            quo_q       <= 8'h00;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s_q         <= s_d;
            r_q         <= r_d;
            a_reg_q     <= a_reg_d;
            dz_q        <= dz_d;
            quo_q       <= quo_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_gf_div.sv
// Testbench for gf_div: directed vectors with hand-computed quotients, reset,
// back-pressure and abort scenarios, then random pairs checked by multiplying
// the quotient back by the divisor.
module tb_gf_div;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] q;
    logic       div_by_zero;

    int checks_cnt;
    int fail_cnt;

    gf_div #(.POLY(8'h1D)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .q          (q),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference multiply: carry-less 16-bit product reduced by 0x11D.
    function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] p;
        logic [15:0] m;
        p = 16'h0000;
        m = {8'h00, x};
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ (m << i);
        end
        for (int i = 15; i >= 8; i--) begin
            if (p[i]) p = p ^ (16'h011D << (i - 8));
        end
        return p[7:0];
    endfunction

    // Issue one operation from IDLE (called #1 after an edge); returns the
    // result and the number of edges from accept to out_valid.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                         output logic [7:0] qv, output logic dzv, output int lat);
        check_eq("ready_before_accept", {31'd0, in_ready}, 32'd1);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("ready_after_accept", {31'd0, in_ready}, 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        qv  = q;
        dzv = div_by_zero;
    endtask

    task automatic op_check(input string tag, input logic [7:0] av, input logic [7:0] bv,
                            input logic [7:0] eq, input logic edz);
        logic [7:0] qv;
        logic       dzv;
        int         lat;
        do_op(av, bv, qv, dzv, lat);
        check_eq({tag, "_lat"}, lat, 32'd8);
        check_eq({tag, "_q"}, {24'd0, qv}, {24'd0, eq});
        check_eq({tag, "_dz"}, {31'd0, dzv}, {31'd0, edz});
        @(posedge clk);
        #1;
        check_eq({tag, "_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] qv;
        logic       dzv;
        int         lat;
        logic [7:0] ra;
        logic [7:0] rb;

        checks_cnt = 0;
        fail_cnt   = 0;
        rst        = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        a          = 8'h00;
        b          = 8'h00;

        // Reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #1;
        check_eq("rst_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_q", {24'd0, q}, 32'd0);
        check_eq("rst_dz", {31'd0, div_by_zero}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        op_check("div_1_2", 8'h01, 8'h02, 8'h8E, 1'b0);
        op_check("div_3_3", 8'h03, 8'h03, 8'h01, 1'b0);
        op_check("div_57_1", 8'h57, 8'h01, 8'h57, 1'b0);
        op_check("div_0_35", 8'h00, 8'h35, 8'h00, 1'b0);
        op_check("div_a5_0", 8'hA5, 8'h00, 8'h00, 1'b1);
        op_check("div_0_0", 8'h00, 8'h00, 8'h00, 1'b1);
        op_check("div_8e_8e", 8'h8E, 8'h8E, 8'h01, 1'b0);

        // Back-pressure: result held in DONE, input pulses ignored.
        out_ready = 1'b0;
        do_op(8'h03, 8'h03, qv, dzv, lat);
        check_eq("bp_lat", lat, 32'd8);
        for (int i = 0; i < 5; i++) begin
            a        = 8'hA5;
            b        = 8'h00;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
            check_eq("bp_q", {24'd0, q}, 32'h01);
            check_eq("bp_dz", {31'd0, div_by_zero}, 32'd0);
            check_eq("bp_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check_eq("bp_release_ready", {31'd0, in_ready}, 32'd1);
        check_eq("bp_retain_q", {24'd0, q}, 32'h01);

        // Abort mid-CALC; in_valid held high through reset is not accepted.
        a        = 8'h57;
        b        = 8'h03;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort_calc_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        rst      = 1'b1;
        #1;
        check_eq("abort_valid", {31'd0, out_valid}, 32'd0);
        check_eq("abort_ready", {31'd0, in_ready}, 32'd1);
        check_eq("abort_q", {24'd0, q}, 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check_eq("rst_no_accept", {31'd0, in_ready}, 32'd1);
        repeat (12) @(posedge clk);
        #1;
        check_eq("abort_no_result", {31'd0, out_valid}, 32'd0);
        op_check("post_abort", 8'h01, 8'h02, 8'h8E, 1'b0);

        // Random pairs, back to back: quotient times divisor must give a.
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            do_op(ra, rb, qv, dzv, lat);
            check_eq("rand_lat", lat, 32'd8);
            check_eq("rand_qb", {24'd0, ref_mul(qv, rb)}, {24'd0, ra});
            check_eq("rand_dz", {31'd0, dzv}, 32'd0);
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/gf_div.md
GF_DIV -- requirements
Module: gf_div

Interface
REQ-001 Parameter: POLY, default 8'h1D, low byte of the GF(2^8) field polynomial x^8+x^4+x^3+x^2+1 (0x11D), the same field the team's combinational multiplier uses.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: in_valid  input  1  operand pair a/b is valid.
REQ-005 Port: in_ready  output  1  block can accept an operand pair.
REQ-006 Port: a  input  8  dividend (field element).
REQ-007 Port: b  input  8  divisor (field element).
REQ-008 Port: out_valid  output  1  result q is valid.
REQ-009 Port: out_ready  input  1  consumer accepts the result.
REQ-010 Port: q  output  8  quotient a * b^-1 in GF(2^8).
REQ-011 Port: div_by_zero  output  1  the accepted b was 8'h00; qualified by out_valid.

Function
REQ-012 The block SHALL compute q = a * b^254 (= a / b for b != 0) by iterative square-and-multiply, one square and one multiply per cycle.
REQ-013 All field multiplies and squares SHALL reduce modulo {1'b1, POLY}; no carries, addition is XOR.
REQ-014 The FSM SHALL have states IDLE, CALC, MUL, DONE.
REQ-015 IDLE: in_ready=1, out_valid=0; in_valid=1 at an edge is an accept: a_reg<=a, s<=b, r<=8'h01, cnt<=0, dz<=(b==0), go to CALC.
REQ-016 CALC: each edge s<=s*s, r<=r*(s*s), cnt<=cnt+1; at the edge where cnt==6 (7th CALC edge) go to MUL.
REQ-017 MUL: at one edge q<=r*a_reg, div_by_zero<=dz, go to DONE.
REQ-018 DONE: out_valid=1, q and div_by_zero held stable; at an edge with out_ready=1 go to IDLE, else stay.
REQ-019 Latency: out_valid SHALL rise exactly 8 edges after the accept edge (7 CALC + 1 MUL), independent of operand values.
REQ-020 in_ready SHALL be 0 in CALC, MUL and DONE; in_valid outside IDLE SHALL be ignored and SHALL NOT alter state.
REQ-021 No result/accept overlap: the earliest next accept is at the edge after the DONE->IDLE edge (minimum 10 cycles per operation).
REQ-022 b==8'h00: q SHALL be 8'h00 and div_by_zero SHALL be 1, at the same latency.
REQ-023 a==8'h00, b!=0: q SHALL be 8'h00 and div_by_zero SHALL be 0.
REQ-024 b==8'h01: q SHALL equal a.
REQ-025 q and div_by_zero SHALL change only at the MUL edge or reset; between operations they retain the last result.
REQ-026 cnt SHALL be 3 bits and SHALL never wrap within an operation.

Reset
REQ-027 rst=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, cnt=0, s=0, r=8'h01, a_reg=0, q=8'h00, div_by_zero=0, out_valid=0, in_ready=1.
REQ-028 rst asserted in CALC, MUL or DONE SHALL abort the operation with no result produced; after release the first accept behaves as from power-up.
REQ-029 in_valid sampled while rst=1 SHALL NOT be accepted.

Verification
REQ-030 a=8'h01, b=8'h02 accepted -> 8 edges later out_valid=1, q=8'h8E, div_by_zero=0.
REQ-031 a=8'h03, b=8'h03 -> q=8'h01; a=8'h57, b=8'h01 -> q=8'h57; a=8'h00, b=8'h35 -> q=8'h00, div_by_zero=0.
REQ-032 a=8'hA5, b=8'h00 -> q=8'h00, div_by_zero=1, latency still 8.
REQ-033 out_ready held 0 for 5 cycles in DONE -> out_valid, q, div_by_zero stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-034 rst pulsed mid-CALC (after the 3rd CALC edge) -> out_valid=0, in_ready=1 immediately; next op a=8'h01, b=8'h02 -> q=8'h8E at latency 8.
REQ-035 1000 random (a, b!=0) pairs, back-to-back with out_ready=1 -> q*b reduced mod 0x11D equals a, checked against a reference model; every accept-to-out_valid gap is 8 edges.
